wb_master_port: RTL and testbench
=================================

Name: wb_master_port

Overview:
- Wishbone B4 pipelined initiator. It turns a simple valid/ready register-access request into one single-beat Wishbone transaction.
- It returns read data, or a timeout error, on a one-cycle response strobe.
- It is the bus-side counterpart of our Wishbone peripherals (UART, etc.). It is used by bridges, DMA-lite engines and test harnesses to drive their register maps.
- One transaction is outstanding at a time.

Parameters:
- TIMEOUT_CYCLES, 256: max cycles from CYC assertion to ACK before an error response. 0 disables the timeout.
- CNT_WIDTH, 9: width of the timeout counter. Must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-low reset
- req_valid_i  in  1  request present
- req_ready_o  out  1  block can accept a request
- req_addr_i  in  32  byte address
- req_we_i  in  1  1=write, 0=read
- req_sel_i  in  4  byte lane select
- req_wdata_i  in  32  write data
- rsp_valid_o  out  1  one-cycle completion strobe
- rsp_rdata_o  out  32  read data (0 for writes/errors)
- rsp_err_o  out  1  timeout occurred; qualified by rsp_valid_o
- wb_adr_o  out  32  address
- wb_dat_o  out  32  write data
- wb_dat_i  in  32  read data
- wb_we_o  out  1  write enable
- wb_sel_o  out  4  byte select
- wb_stb_o  out  1  strobe
- wb_ack_i  in  1  acknowledge
- wb_cyc_o  out  1  cycle
- wb_stall_i  in  1  stall

Behaviour:
- Reset (rst_i=0, asynchronous): state IDLE.
  - All outputs 0, except req_ready_o, which is 1 only after reset deasserts.
  - Timeout counter 0; latched request fields 0.
- States: IDLE, REQUEST, WAIT_ACK, RESPOND.
- IDLE:
  - req_ready_o=1; cyc/stb=0.
  - On req_valid_i && req_ready_o: latch addr/we/sel/wdata, clear counter, go to REQUEST.
- REQUEST:
  - cyc=stb=1; wb_adr/dat/we/sel driven from the latched fields and stable until the state is left.
  - wb_stall_i=1: stay; stb held.
  - wb_stall_i=0: strobe accepted.
    - If wb_ack_i is also 1 → RESPOND.
    - Else → WAIT_ACK with stb=0 next cycle.
  - An ack while stall=1 is ignored.
- WAIT_ACK: cyc=1, stb=0; on wb_ack_i → RESPOND.
- Read data capture: on the accepting ack, rsp_rdata_o is captured from wb_dat_i for reads; it is 0 for writes.
- Timeout:
  - The counter increments every cycle in REQUEST and WAIT_ACK.
  - If TIMEOUT_CYCLES≠0 and counter==TIMEOUT_CYCLES-1 with no valid ack that cycle → RESPOND with err=1, rdata=0.
  - cyc/stb drop on the next cycle. A late ack arriving afterwards is ignored.
  - If ack and timeout coincide, the ack wins (err=0).
- RESPOND:
  - Lasts exactly one cycle: rsp_valid_o=1, cyc=stb=0, req_ready_o=0.
  - Then → IDLE.
  - rsp_rdata_o/rsp_err_o hold their value until the next response.
- Latency, zero-stall slave acking one cycle after stb:
  - Accept edge T0.
  - cyc/stb high in T1.
  - Ack in T2.
  - rsp_valid in T3.
  - req_ready again in T4.
- No back-to-back pipelining: exactly one stb beat per CYC.
- A req_valid_i while not ready is not consumed; the requester holds it.
- All outputs are registered; no combinational path from Wishbone inputs to Wishbone outputs.
- Reset mid-transaction: cyc/stb drop immediately (async), no response is produced, state IDLE.

Test Plan:
- Read, stall=0, slave acks next cycle with dat=0xDEADBEEF, req addr=0x4:
  - wb_adr_o=0x4, we=0, stb high exactly 1 cycle.
  - rsp_valid one cycle in T3 with rdata=0xDEADBEEF, err=0.
- Write addr=0xC, wdata=0x41, sel=0xF, stall held 3 cycles:
  - stb/adr/dat stable for 4 cycles, stb drops after the first non-stalled cycle.
  - rsp_valid with rdata=0, err=0.
- No ack, TIMEOUT_CYCLES=8:
  - cyc high for exactly 8 cycles, then rsp_valid with err=1, rdata=0.
  - An ack injected 2 cycles later is ignored and req_ready_o=1.
- Ack arriving on the same cycle as the timeout (counter=7, TIMEOUT_CYCLES=8): rsp err=0, rdata=wb_dat_i.
- Assert rst_i=0 while in WAIT_ACK:
  - cyc/stb/rsp_valid go 0 without a clock edge.
  - After release, req_ready_o=1 and a new read completes normally.
- Back-to-back requests with req_valid_i held high: two separate CYC periods with ≥1 idle cycle between them, and two rsp_valid pulses in order.

Source files
------------

// File: rtl/wb_master_port_if.sv
// Request/response and Wishbone B4 pipelined signals of one initiator port.
// The master modport is the initiator's own view; slave is the view of everything around it.
interface wb_master_port_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        req_we_i;
  logic [3:0]  req_sel_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_ack_i;
  logic        wb_cyc_o;
  logic        wb_stall_i;

  modport master (
    input  req_valid_i, req_addr_i, req_we_i, req_sel_i, req_wdata_i,
    input  wb_dat_i, wb_ack_i, wb_stall_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
  );

  modport slave (
    output req_valid_i, req_addr_i, req_we_i, req_sel_i, req_wdata_i,
    output wb_dat_i, wb_ack_i, wb_stall_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
  );
endinterface

// File: rtl/wb_master_port.sv
// Single-beat Wishbone B4 pipelined initiator: one valid/ready request in,
// one registered response strobe out, with an optional ack timeout.
module wb_master_port #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_WIDTH      = 9
) (
  input logic              clk_i,
  input logic              rst_i,
  wb_master_port_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQUEST  = 2'd1,
    S_WAIT_ACK = 2'd2,
    S_RESPOND  = 2'd3
  } state_t;

  localparam bit                   LP_TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] LP_LAST  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t               r_state;
  state_t               w_next;
  logic                 r_ready;
  logic                 r_cyc;
  logic                 r_stb;
  logic                 r_rsp_valid;
  logic [31:0]          r_rdata;
  logic                 r_err;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [31:0]          r_addr;
  logic                 r_we;
  logic [3:0]           r_sel;
  logic [31:0]          r_wdata;

  logic w_accept;
  logic w_busy;
  logic w_ack_ok;
  logic w_timeout;
  logic w_ready_d;
  logic w_cyc_d;
  logic w_stb_d;
  logic w_rsp_d;

  assign w_accept = r_ready & bus.req_valid_i;
  assign w_busy   = (r_state == S_REQUEST) | (r_state == S_WAIT_ACK);
  // An ack only counts once the strobe has been (or is being) accepted.
  assign w_ack_ok = bus.wb_ack_i &
                    (((r_state == S_REQUEST) & ~bus.wb_stall_i) | (r_state == S_WAIT_ACK));
  assign w_timeout = LP_TO_EN & w_busy & (r_cnt == LP_LAST) & ~w_ack_ok;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:     if (w_accept) w_next = S_REQUEST;
      S_REQUEST: begin
        if (w_ack_ok || w_timeout) w_next = S_RESPOND;
        else if (!bus.wb_stall_i)  w_next = S_WAIT_ACK;
      end
      S_WAIT_ACK: if (w_ack_ok || w_timeout) w_next = S_RESPOND;
      S_RESPOND:  w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase

    w_ready_d = (w_next == S_IDLE);
    w_cyc_d   = (w_next == S_REQUEST) | (w_next == S_WAIT_ACK);
    w_stb_d   = (w_next == S_REQUEST);
    w_rsp_d   = (w_next == S_RESPOND);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_ready     <= w_ready_d;
      r_cyc       <= w_cyc_d;
      r_stb       <= w_stb_d;
      r_rsp_valid <= w_rsp_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_sel   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr  <= bus.req_addr_i;
        r_we    <= bus.req_we_i;
        r_sel   <= bus.req_sel_i;
        r_wdata <= bus.req_wdata_i;
        r_cnt   <= '0;
      end else if (w_busy) begin
        r_cnt <= r_cnt + 1'b1;
      end

      // Ack takes priority over a coinciding timeout; both hold until the next response.
      if (w_ack_ok) begin
        r_rdata <= r_we ? 32'h0 : bus.wb_dat_i;
        r_err   <= 1'b0;
      end else if (w_timeout) begin
        r_rdata <= 32'h0;
        r_err   <= 1'b1;
      end
    end
  end

  assign bus.req_ready_o = r_ready;
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_rdata_o = r_rdata;
  assign bus.rsp_err_o   = r_err;
  assign bus.wb_adr_o    = r_addr;
  assign bus.wb_dat_o    = r_wdata;
  assign bus.wb_we_o     = r_we;
  assign bus.wb_sel_o    = r_sel;
  assign bus.wb_cyc_o    = r_cyc;
  assign bus.wb_stb_o    = r_stb;

endmodule

// File: tb/tb_wb_master_port.sv
// Self-checking bench for wb_master_port: directed corner cases plus randomized
// transactions against a cycle-count model of stall, ack delay and timeout.
module tb_wb_master_port;
  localparam int unsigned TO = 8;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  wb_master_port_if bus ();

  wb_master_port #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(4)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_wb_inputs();
    bus.wb_ack_i   = 1'b0;
    bus.wb_stall_i = 1'b0;
    bus.wb_dat_i   = 32'h0;
  endtask

  // Model: cycle k counts from the first cycle with cyc high. The strobe is
  // accepted at k=stall_n, the ack lands at k=stall_n+ack_dly; the ack is valid
  // only if it lands at k<=TO-1, otherwise the port times out after TO cycles.
  task automatic run_txn(input logic [31:0] addr, input logic we, input logic [3:0] sel,
                         input logic [31:0] wdata, input logic [31:0] rdat,
                         input int stall_n, input int ack_dly);
    int          ack_at;
    int          exp_cyc;
    int          exp_stb;
    logic        exp_err;
    logic [31:0] exp_rdata;
    ack_at = stall_n + ack_dly;
    if (ack_at <= int'(TO) - 1) begin
      exp_cyc   = ack_at + 1;
      exp_stb   = stall_n + 1;
      exp_err   = 1'b0;
      exp_rdata = we ? 32'h0 : rdat;
    end else begin
      exp_cyc   = TO;
      exp_stb   = (stall_n + 1 < int'(TO)) ? stall_n + 1 : int'(TO);
      exp_err   = 1'b1;
      exp_rdata = 32'h0;
    end

    check("ready_before", bus.req_ready_o, 1);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = addr;
    bus.req_we_i    = we;
    bus.req_sel_i   = sel;
    bus.req_wdata_i = wdata;
    @(negedge clk_i);
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = $urandom;
    bus.req_wdata_i = $urandom;
    bus.req_sel_i   = 4'($urandom);
    bus.req_we_i    = ~we;

    for (int k = 0; k <= exp_cyc; k++) begin
      check("cyc", bus.wb_cyc_o, k < exp_cyc);
      check("stb", bus.wb_stb_o, k < exp_stb);
      check("rsp_valid", bus.rsp_valid_o, k == exp_cyc);
      if (k < exp_cyc) begin
        check("wb_adr", bus.wb_adr_o, addr);
        check("wb_dat_o", bus.wb_dat_o, wdata);
        check("wb_we", bus.wb_we_o, we);
        check("wb_sel", bus.wb_sel_o, sel);
      end else begin
        check("rsp_rdata", bus.rsp_rdata_o, exp_rdata);
        check("rsp_err", bus.rsp_err_o, exp_err);
      end
      bus.wb_stall_i = (k < stall_n);
      bus.wb_ack_i   = (k == ack_at) || ((k < stall_n) && ($urandom_range(0, 1) == 1));
      bus.wb_dat_i   = (k == ack_at) ? rdat : $urandom;
      @(negedge clk_i);
    end
    clear_wb_inputs();
    check("rsp_one_cycle", bus.rsp_valid_o, 0);
    check("ready_after", bus.req_ready_o, 1);
    check("cyc_after", bus.wb_cyc_o, 0);
    check("rdata_hold", bus.rsp_rdata_o, exp_rdata);
    check("err_hold", bus.rsp_err_o, exp_err);
  endtask

  task automatic back_to_back();
    logic [31:0] a1;
    logic [31:0] a2;
    logic [31:0] got[$];
    int          starts;
    int          gap;
    int          min_gap;
    logic        prev_cyc;
    a1 = 32'h0000_1230;
    a2 = 32'h0000_4560;
    starts = 0;
    gap = 0;
    min_gap = 1000;
    prev_cyc = 1'b0;
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = a1;
    bus.req_we_i    = 1'b0;
    bus.req_sel_i   = 4'hF;
    bus.req_wdata_i = 32'h0;
    for (int c = 0; c < 16; c++) begin
      if (bus.wb_cyc_o && !prev_cyc) begin
        starts++;
        if (starts > 1 && gap < min_gap) min_gap = gap;
        gap = 0;
      end else if (!bus.wb_cyc_o) begin
        gap++;
      end
      if (bus.rsp_valid_o) got.push_back(bus.rsp_rdata_o);
      bus.wb_ack_i = bus.wb_cyc_o && !bus.wb_stb_o;
      bus.wb_dat_i = {16'hC0DE, bus.wb_adr_o[15:0]};
      if (starts == 1) bus.req_addr_i = a2;
      if (starts >= 2) bus.req_valid_i = 1'b0;
      prev_cyc = bus.wb_cyc_o;
      @(negedge clk_i);
    end
    clear_wb_inputs();
    check("b2b_cyc_periods", starts, 2);
    check("b2b_rsp_count", got.size(), 2);
    check("b2b_idle_gap", min_gap >= 1, 1);
    if (got.size() >= 2) begin
      check("b2b_rsp0", got[0], {16'hC0DE, a1[15:0]});
      check("b2b_rsp1", got[1], {16'hC0DE, a2[15:0]});
    end
  endtask

  initial begin
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = 32'h0;
    bus.req_we_i    = 1'b0;
    bus.req_sel_i   = 4'h0;
    bus.req_wdata_i = 32'h0;
    clear_wb_inputs();

    #1;
    check("rst_ready", bus.req_ready_o, 0);
    check("rst_cyc", bus.wb_cyc_o, 0);
    check("rst_stb", bus.wb_stb_o, 0);
    check("rst_rsp_valid", bus.rsp_valid_o, 0);
    check("rst_rdata", bus.rsp_rdata_o, 0);
    check("rst_err", bus.rsp_err_o, 0);
    check("rst_adr", bus.wb_adr_o, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("ready_post_rst", bus.req_ready_o, 1);

    // Zero-stall read acked the cycle after the strobe.
    run_txn(32'h4, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 0, 1);
    // Write with the strobe stalled for three cycles.
    run_txn(32'hC, 1'b1, 4'hF, 32'h41, 32'h5555_AAAA, 3, 1);
    // No ack at all: timeout, then a late ack must be ignored.
    run_txn(32'h20, 1'b0, 4'h3, 32'h0, 32'h1234_5678, 0, 50);
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'hBAD0_BAD0;
    @(negedge clk_i);
    clear_wb_inputs();
    check("late_ack_rsp", bus.rsp_valid_o, 0);
    check("late_ack_cyc", bus.wb_cyc_o, 0);
    check("late_ack_ready", bus.req_ready_o, 1);
    check("late_ack_err", bus.rsp_err_o, 1);
    // Ack exactly on the last counted cycle wins over the timeout.
    run_txn(32'h24, 1'b0, 4'hF, 32'h0, 32'hCAFE_F00D, 2, 5);
    // Just past the limit: timeout.
    run_txn(32'h28, 1'b0, 4'hF, 32'h0, 32'hCAFE_F00D, 2, 6);

    // Asynchronous reset while waiting for the ack.
    check("mid_ready", bus.req_ready_o, 1);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 32'h10;
    bus.req_we_i    = 1'b0;
    bus.req_sel_i   = 4'hF;
    @(negedge clk_i);
    bus.req_valid_i = 1'b0;
    @(negedge clk_i);
    check("mid_wait_cyc", bus.wb_cyc_o, 1);
    check("mid_wait_stb", bus.wb_stb_o, 0);
    #2 rst_i = 1'b0;
    #1;
    check("mid_rst_cyc", bus.wb_cyc_o, 0);
    check("mid_rst_stb", bus.wb_stb_o, 0);
    check("mid_rst_rsp", bus.rsp_valid_o, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("mid_rel_ready", bus.req_ready_o, 1);
    check("mid_rel_rsp", bus.rsp_valid_o, 0);
    run_txn(32'h10, 1'b0, 4'hF, 32'h0, 32'h0BAD_CAFE, 0, 1);

    back_to_back();
    @(negedge clk_i);

    for (int t = 0; t < 40; t++) begin
      int dly;
      dly = ($urandom_range(0, 4) == 0) ? 20 : int'($urandom_range(0, 6));
      run_txn($urandom, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom,
              int'($urandom_range(0, 3)), dly);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
